valid_stream_to_ready_fifo: RTL and testbench
=============================================

// Module: valid_stream_to_ready_fifo
//
// PURPOSE
//  Downstream consumer of the valid-only shift-register pipeline stage.
//  - Captures every in_vld transfer; the source has no backpressure.
//  - Buffers transfers in a small FIFO and re-issues them on a valid/ready interface.
//  - Lets a stalling consumer (out_rdy=0) sit behind a pipeline that cannot stop.
//  - Transfers arriving while the FIFO is full are dropped and flagged.
//
// PARAMETERS
//  width  8  data bits per transfer
//  depth  4  FIFO entries; power of two, >= 2
//
// PORTS
//  clk       in   1                 clock, rising edge
//  rst       in   1                 reset, asynchronous, active-high
//  in_vld    in   1                 upstream transfer valid; no ready returned
//  in_data   in   width             upstream data, sampled when in_vld=1
//  out_vld   out  1                 FIFO non-empty; out_data valid
//  out_rdy   in   1                 consumer accepts when out_vld & out_rdy
//  out_data  out  width             head-of-FIFO data
//  full      out  1                 depth entries held
//  empty     out  1                 zero entries held
//  overflow  out  1                 sticky: a transfer was dropped since reset
//
// BEHAVIOUR
//  - Reset values:
//      - Pointers = 0, out_vld = 0, empty = 1, full = 0, overflow = 0.
//      - out_data = 0. Storage is also cleared.
//  - Pointers: wr_ptr and rd_ptr are each $clog2(depth)+1 bits. The MSB is the wrap bit.
//      - empty = (wr_ptr == rd_ptr).
//      - full  = equal index bits AND differing wrap bits.
//  - push = in_vld & (~full | pop).
//  - pop  = out_vld & out_rdy.
//  - out_vld = ~empty. out_data = mem[rd_ptr index] is read combinationally from registers.
//  - Latency: data pushed at edge N is visible on out_data/out_vld after edge N.
//      - There is no combinational in->out bypass.
//  - Simultaneous push and pop:
//      - Allowed in every state, including full.
//      - Occupancy is unchanged and both pointers advance.
//  - in_vld=1 while full and no pop:
//      - The transfer is dropped. The FIFO and its pointers are unchanged.
//      - overflow sets at that edge and holds until rst.
//  - pop while empty: impossible, because out_vld=0. out_rdy is ignored while empty.
//  - Wrap-around: pointers wrap modulo 2*depth. FIFO order is preserved across the wrap.
//  - out_data is held stable while out_vld=1 and out_rdy=0.
//  - rst asserted mid-operation:
//      - All contents are discarded immediately (async).
//      - Outputs return to their reset values without waiting for clk.
//
// CONFIGURATION
//  VALID_STREAM_FIFO_LEVEL_EN
//  - Defined:
//      - Adds output port level [$clog2(depth):0] = wr_ptr - rd_ptr (occupancy, 0..depth).
//      - level is 0 on reset and is updated on the same edge as the pointers.
//  - Undefined:
//      - The level port is absent.
//      - The rest of the behaviour is identical.
//
// TESTING
//  1. Reset, out_rdy=1, push 8'h11, 8'h22 on consecutive cycles.
//     -> out_data 11 then 22, each one cycle after its push. empty=1 afterwards.
//  2. out_rdy=0, push 4 values A0..A3.
//     -> full=1 after the 4th edge. A 5th push of A4 is dropped and overflow=1.
//     -> Then out_rdy=1 drains A0..A3 in order.
//  3. Full FIFO, in_vld=1 and out_rdy=1 together for 3 cycles.
//     -> Nothing dropped, overflow stays 0, full stays 1, order preserved.
//  4. Stream 20 pushes with out_rdy toggling 1/0, keeping occupancy <= depth.
//     -> Output is an exact in-order copy across pointer wraps.
//  5. Assert rst async mid-stream with 3 entries held.
//     -> out_vld=0, empty=1, overflow=0 before the next clk edge.
//  6. With VALID_STREAM_FIFO_LEVEL_EN defined:
//     -> Pushes 0..3 give level 1,2,3,4.
//     -> A simultaneous push+pop leaves level unchanged.

Source files
------------

// File: rtl/valid_stream_to_ready_fifo.sv
// Buffers a no-backpressure valid stream into a small FIFO and re-issues it on valid/ready.
// Optional build macro VALID_STREAM_FIFO_LEVEL_EN adds the occupancy output 'level'.
module valid_stream_to_ready_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [width-1:0] in_data,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [width-1:0] out_data,
    output logic             full,
    output logic             empty,
    output logic             overflow
`ifdef VALID_STREAM_FIFO_LEVEL_EN
    ,
    output logic [$clog2(depth):0] level
`endif
);

    localparam int aw = $clog2(depth);

    logic [aw:0]      wr_ptr;
    logic [aw:0]      rd_ptr;
    logic [width-1:0] mem [depth];
    logic             push;
    logic             pop;

    // The extra MSB on each pointer distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]) && (wr_ptr[aw] != rd_ptr[aw]);
    assign out_vld  = ~empty;
    assign out_data = mem[rd_ptr[aw-1:0]];

    assign pop  = out_vld & out_rdy;
    assign push = in_vld & (~full | pop);

`ifdef VALID_STREAM_FIFO_LEVEL_EN
    assign level = wr_ptr - rd_ptr;
`endif

    // A pop frees the head slot on the same edge, so a full FIFO can still accept a push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[aw-1:0]] <= in_data;
                wr_ptr              <= wr_ptr + (aw+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (aw+1)'(1);
            end
            if (in_vld && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_valid_stream_to_ready_fifo.sv
// Self-checking bench for valid_stream_to_ready_fifo: queue-based reference model plus directed and random stimulus.
// Build with VALID_STREAM_FIFO_LEVEL_EN defined to also exercise the level output.
module tb_valid_stream_to_ready_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_vld = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_vld;
    logic             out_rdy = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             full;
    logic             empty;
    logic             overflow;
`ifdef VALID_STREAM_FIFO_LEVEL_EN
    logic [$clog2(DEPTH):0] level;
`endif

    int compared = 0;
    int mismatched = 0;

    // Reference model: plain queue of held transfers plus the sticky drop flag.
    logic [WIDTH-1:0] q[$];
    bit               m_ovf = 1'b0;

    valid_stream_to_ready_fifo #(.width(WIDTH), .depth(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
`ifdef VALID_STREAM_FIFO_LEVEL_EN
        ,
        .level    (level)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit vld, input logic [WIDTH-1:0] data, input bit rdy);
        in_vld  = vld;
        in_data = data;
        out_rdy = rdy;
    endtask

    // Advance the model by one edge using the inputs present at that edge.
    task automatic modelStep();
        bit m_pop;
        bit m_full;
        bit m_push;
        m_pop  = (q.size() > 0) && out_rdy;
        m_full = (q.size() == DEPTH);
        m_push = in_vld && (!m_full || m_pop);
        if (in_vld && m_full && !m_pop) m_ovf = 1'b1;
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back(in_data);
    endtask

    task automatic checkOutput();
        check("out_vld", out_vld, (q.size() > 0));
        check("empty", empty, (q.size() == 0));
        check("full", full, (q.size() == DEPTH));
        check("overflow", overflow, m_ovf);
        if (q.size() > 0) check("out_data", out_data, q[0]);
`ifdef VALID_STREAM_FIFO_LEVEL_EN
        check("level", level, q.size());
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    // Pulse reset between clock edges and confirm outputs clear before any edge arrives.
    task automatic doReset();
        applyStimulus(1'b0, '0, 1'b0);
        #2;
        rst = 1'b1;
        q.delete();
        m_ovf = 1'b0;
        #1;
        check("rst_out_vld", out_vld, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_out_data", out_data, 0);
`ifdef VALID_STREAM_FIFO_LEVEL_EN
        check("rst_level", level, 0);
`endif
        #1;
        rst = 1'b0;
    endtask

    initial begin
        $display("[TB] start");
        doReset();

        // Two back-to-back pushes with a ready consumer.
        applyStimulus(1'b1, 8'h11, 1'b1);
        tick();
        check("t1_first", out_data, 8'h11);
        applyStimulus(1'b1, 8'h22, 1'b1);
        tick();
        check("t1_second", out_data, 8'h22);
        applyStimulus(1'b0, '0, 1'b1);
        tick();
        check("t1_empty", empty, 1);

        // Fill while stalled, drop one, then drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0);
            tick();
        end
        check("t2_full", full, 1);
        check("t2_no_ovf", overflow, 0);
        applyStimulus(1'b1, 8'hA4, 1'b0);
        tick();
        check("t2_ovf", overflow, 1);
        check("t2_head", out_data, 8'hA0);
        for (int i = 0; i < DEPTH; i++) begin
            check("t2_drain", out_data, 8'hA0 + 8'(i));
            applyStimulus(1'b0, '0, 1'b1);
            tick();
        end
        check("t2_empty", empty, 1);
        check("t2_ovf_sticky", overflow, 1);

        // Push and pop together while full: nothing dropped.
        doReset();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 8'hB0 + 8'(i), 1'b0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'hB4 + 8'(i), 1'b1);
            tick();
            check("t3_full", full, 1);
            check("t3_no_ovf", overflow, 0);
        end
        check("t3_head", out_data, 8'hB3);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            tick();
        end
        check("t3_empty", empty, 1);

        // Streaming across pointer wraps with a toggling consumer.
        for (int i = 0; i < 40; i++) begin
            applyStimulus((i % 2) == 0, 8'h40 + 8'(i / 2), (i % 2) == 1);
            tick();
        end
        check("t4_no_ovf", overflow, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 2) != 0));
            tick();
        end

        // Async reset mid-stream with three entries held and overflow set.
        doReset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b0);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b1);
        tick();
        check("t5_held3_ovf", overflow, 1);
        check("t5_held3_vld", out_vld, 1);
        doReset();
        applyStimulus(1'b0, '0, 1'b0);
        tick();

`ifdef VALID_STREAM_FIFO_LEVEL_EN
        // Occupancy counts up with each push and holds on push+pop.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0);
            tick();
            check("t6_level", level, i + 1);
        end
        applyStimulus(1'b1, 8'h55, 1'b1);
        tick();
        check("t6_level_hold", level, DEPTH);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
